// File: rtl/sha3_byte_packer.sv
// sha3_byte_packer: packs the UART receive byte stream into 32-bit words for the
// Keccak padder. The first byte of each word lands in bits [31:24]. The final word
// is flagged with pad_is_last and a residual byte count. A message whose length is
// a multiple of four is followed by an empty final word.
// Optional feature: define SHA3_PACKER_LEN_EN to get a saturating 16-bit msg_len
// byte counter; otherwise msg_len is tied to zero.
module sha3_byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  byte_data,
    input  logic        byte_valid,
    input  logic        byte_last,
    output logic        byte_ready,
    input  logic        msg_clear,
    input  logic        buffer_full,
    output logic [31:0] pad_in,
    output logic        pad_in_ready,
    output logic        pad_is_last,
    output logic [1:0]  pad_byte_num,
    output logic [15:0] msg_len
);

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = 2;
    localparam int unsigned LEN_W  = 16;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        HOLD = 2'd1,
        TAIL = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state, state_d;
    logic [WORD_W-1:0]   acc, acc_d;
    logic [CNT_W-1:0]    cnt, cnt_d;
    logic [CNT_W-1:0]    byte_num, byte_num_d;
    logic                tail_pend, tail_pend_d;
    logic                last, last_d;

    logic                byte_ready_d;
    logic [WORD_W-1:0]   pad_in_d;
    logic                pad_in_ready_d;
    logic                pad_is_last_d;
    logic [CNT_W-1:0]    pad_byte_num_d;

    logic                xfer;
    logic [WORD_W-1:0]   acc_ins;
    logic [WORD_W-1:0]   keep_mask;

    // A byte moves only while the registered byte_ready is high
    assign xfer = byte_valid & byte_ready;

    // Merge the incoming byte into its lane and build the mask of filled lanes
    always_comb begin
        acc_ins   = acc;
        keep_mask = 32'hFFFF_FFFF;
        case (cnt)
            2'd0: begin
                acc_ins   = {byte_data, acc[23:0]};
                keep_mask = 32'hFF00_0000;
            end
            2'd1: begin
                acc_ins   = {acc[31:24], byte_data, acc[15:0]};
                keep_mask = 32'hFFFF_0000;
            end
            2'd2: begin
                acc_ins   = {acc[31:16], byte_data, acc[7:0]};
                keep_mask = 32'hFFFF_FF00;
            end
            default: begin
                acc_ins   = {acc[31:BYTE_W], byte_data};
                keep_mask = 32'hFFFF_FFFF;
            end
        endcase
    end

    // State register plus all datapath and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= FILL;
            acc          <= '0;
            cnt          <= '0;
            byte_num     <= '0;
            tail_pend    <= 1'b0;
            last         <= 1'b0;
            byte_ready   <= 1'b1;
            pad_in       <= '0;
            pad_in_ready <= 1'b0;
            pad_is_last  <= 1'b0;
            pad_byte_num <= '0;
        end else begin
            state        <= state_d;
            acc          <= acc_d;
            cnt          <= cnt_d;
            byte_num     <= byte_num_d;
            tail_pend    <= tail_pend_d;
            last         <= last_d;
            byte_ready   <= byte_ready_d;
            pad_in       <= pad_in_d;
            pad_in_ready <= pad_in_ready_d;
            pad_is_last  <= pad_is_last_d;
            pad_byte_num <= pad_byte_num_d;
        end
    end

    // Next-state and datapath update; msg_clear wins over any same-cycle event
    always_comb begin
        state_d     = state;
        acc_d       = acc;
        cnt_d       = cnt;
        byte_num_d  = byte_num;
        tail_pend_d = tail_pend;
        last_d      = last;
        case (state)
            FILL: begin
                if (xfer) begin
                    acc_d = acc_ins;
                    cnt_d = cnt + CNT_W'(1);
                    if (cnt == 2'd3) begin
                        state_d     = HOLD;
                        last_d      = 1'b0;
                        byte_num_d  = '0;
                        tail_pend_d = byte_last;
                    end else if (byte_last) begin
                        state_d    = HOLD;
                        last_d     = 1'b1;
                        byte_num_d = cnt + CNT_W'(1);
                        acc_d      = acc_ins & keep_mask;
                    end
                end
            end
            HOLD: begin
                if (!buffer_full) begin
                    if (tail_pend) begin
                        state_d = TAIL;
                    end else if (last) begin
                        state_d = DONE;
                    end else begin
                        state_d = FILL;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end
                end
            end
            TAIL: begin
                if (!buffer_full) begin
                    tail_pend_d = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = FILL;
            end
        endcase
        if (msg_clear) begin
            state_d     = FILL;
            acc_d       = '0;
            cnt_d       = '0;
            byte_num_d  = '0;
            tail_pend_d = 1'b0;
            last_d      = 1'b0;
        end
    end

    // Output decode of the next state so every output leaves a flop
    always_comb begin
        byte_ready_d   = 1'b0;
        pad_in_d       = '0;
        pad_in_ready_d = 1'b0;
        pad_is_last_d  = 1'b0;
        pad_byte_num_d = '0;
        case (state_d)
            FILL: begin
                byte_ready_d = 1'b1;
            end
            HOLD: begin
                pad_in_d       = acc_d;
                pad_in_ready_d = 1'b1;
                pad_is_last_d  = last_d;
                pad_byte_num_d = last_d ? byte_num_d : CNT_W'(0);
            end
            TAIL: begin
                pad_in_ready_d = 1'b1;
                pad_is_last_d  = 1'b1;
            end
            default: begin
                byte_ready_d = 1'b0;
            end
        endcase
    end

`ifdef SHA3_PACKER_LEN_EN
    logic [LEN_W-1:0] len_cnt, len_cnt_d;

    // Saturating count of bytes accepted in this message
    always_comb begin
        len_cnt_d = len_cnt;
        if (xfer && (state == FILL) && (len_cnt != 16'hFFFF)) begin
            len_cnt_d = len_cnt + LEN_W'(1);
        end
        if (msg_clear) begin
            len_cnt_d = '0;
        end
    end

    // Byte counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_cnt <= '0;
        end else begin
            len_cnt <= len_cnt_d;
        end
    end

    assign msg_len = len_cnt;
`else
    assign msg_len = LEN_W'(0);
`endif

endmodule

// File: tb/tb_sha3_byte_packer.sv
// Self-checking bench for sha3_byte_packer: table vectors, hand-written corner
// sequences and randomized messages against a word-level reference model.
module tb_sha3_byte_packer;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  byte_data;
    logic        byte_valid;
    logic        byte_last;
    logic        byte_ready;
    logic        msg_clear;
    logic        buffer_full;
    logic [31:0] pad_in;
    logic        pad_in_ready;
    logic        pad_is_last;
    logic [1:0]  pad_byte_num;
    logic [15:0] msg_len;

    sha3_byte_packer dut (
        .clk          (clk),
        .reset        (reset),
        .byte_data    (byte_data),
        .byte_valid   (byte_valid),
        .byte_last    (byte_last),
        .byte_ready   (byte_ready),
        .msg_clear    (msg_clear),
        .buffer_full  (buffer_full),
        .pad_in       (pad_in),
        .pad_in_ready (pad_in_ready),
        .pad_is_last  (pad_is_last),
        .pad_byte_num (pad_byte_num),
        .msg_len      (msg_len)
    );

    always #5 clk = ~clk;

    // {word, is_last, byte_num}
    typedef logic [34:0] rec_t;

    typedef struct packed {
        logic [3:0]   len;
        logic [63:0]  bytes;
        logic [1:0]   nw;
        logic [104:0] words;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] msg_q[$];
    rec_t       got_q[$];
    rec_t       exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: split the message into 4-byte groups, pad the last one
    function automatic void build_exp();
        int n;
        int k;
        logic [31:0] w;
        n = msg_q.size();
        exp_q.delete();
        for (int i = 0; i < n; i += 4) begin
            k = (n - i >= 4) ? 4 : n - i;
            w = 32'h0;
            for (int j = 0; j < k; j++) w[31-8*j -: 8] = msg_q[i+j];
            if (k == 4) exp_q.push_back({w, 1'b0, 2'd0});
            else        exp_q.push_back({w, 1'b1, 2'(k)});
        end
        if (n % 4 == 0) exp_q.push_back({32'h0, 1'b1, 2'd0});
    endfunction

    // Stream msg_q into the DUT and collect consumed words until the final one
    task automatic run_msg(input int vld_pct, input int bf_pct, input int max_cyc);
        logic [7:0] tx[$];
        int   cyc;
        bit   done;
        bit   inv_ok;
        bit   was_stalled;
        rec_t held;
        tx = msg_q;
        got_q.delete();
        cyc = 0; done = 0; inv_ok = 1; was_stalled = 0; held = '0;
        while (!done && cyc < max_cyc) begin
            @(negedge clk);
            if (was_stalled && (({pad_in, pad_is_last, pad_byte_num} !== held) || !pad_in_ready))
                inv_ok = 0;
            if (pad_is_last && !pad_in_ready) inv_ok = 0;
            if (!pad_is_last && pad_byte_num != 2'd0) inv_ok = 0;
            if (pad_in_ready && byte_ready) inv_ok = 0;
            byte_valid  = (tx.size() > 0) && (int'($urandom_range(99)) < vld_pct);
            byte_data   = byte_valid ? tx[0] : 8'($urandom);
            byte_last   = byte_valid ? (tx.size() == 1) : 1'($urandom);
            buffer_full = int'($urandom_range(99)) < bf_pct;
            if (byte_valid && byte_ready) void'(tx.pop_front());
            held        = {pad_in, pad_is_last, pad_byte_num};
            was_stalled = pad_in_ready && buffer_full;
            if (pad_in_ready && !buffer_full) begin
                got_q.push_back(held);
                if (pad_is_last) done = 1;
            end
            cyc++;
        end
        check("final_word_seen", 64'(done), 64'd1);
        check("handshake_invariants", 64'(inv_ok), 64'd1);
    endtask

    task automatic compare_words(input string tag);
        check({tag, "_word_count"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("%s_word%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    endtask

    // Verify DONE holds, msg_len, then clear back to FILL
    task automatic finish_msg(input string tag, input int len);
        @(negedge clk);
        byte_valid  = 1'b0;
        byte_last   = 1'b0;
        buffer_full = 1'b0;
        check({tag, "_done_outputs"},
              64'({pad_in_ready, pad_is_last, pad_byte_num, byte_ready}), 64'd0);
`ifdef SHA3_PACKER_LEN_EN
        check({tag, "_msg_len"}, 64'(msg_len), 64'(len));
`else
        check({tag, "_msg_len"}, 64'(msg_len), 64'(len * 0));
`endif
        repeat (3) @(negedge clk);
        check({tag, "_done_hold"}, 64'({pad_in_ready, byte_ready}), 64'd0);
        msg_clear = 1'b1;
        @(negedge clk);
        msg_clear = 1'b0;
        check({tag, "_clear_ready"}, 64'({byte_ready, msg_len}), 64'h1_0000);
    endtask

    // Send one byte when the packer is ready, then release valid
    task automatic push_byte(input logic [7:0] d, input logic l);
        int g;
        g = 0;
        @(negedge clk);
        while (!byte_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!byte_ready) check("push_ready_timeout", 64'd0, 64'd1);
        byte_valid = 1'b1;
        byte_data  = d;
        byte_last  = l;
        @(negedge clk);
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {byte_ready, pad_in, pad_in_ready, pad_is_last, pad_byte_num, msg_len},
              {1'b1, 32'h0, 1'b0, 1'b0, 2'd0, 16'h0});
    endtask

    vec_t vecs[6];
    bit   stable;
    logic [31:0] held_word;
    int   len;

    initial begin
        reset       = 1'b1;
        byte_data   = 8'h00;
        byte_valid  = 1'b0;
        byte_last   = 1'b0;
        msg_clear   = 1'b0;
        buffer_full = 1'b0;

        vecs[0] = '{4'd3, 64'h6162630000000000, 2'd1,
                    {{32'h61626300, 1'b1, 2'd3}, 35'd0, 35'd0}};
        vecs[1] = '{4'd8, 64'h0102030405060708, 2'd3,
                    {{32'h01020304, 1'b0, 2'd0}, {32'h05060708, 1'b0, 2'd0}, {32'h00000000, 1'b1, 2'd0}}};
        vecs[2] = '{4'd1, 64'hAA00000000000000, 2'd1,
                    {{32'hAA000000, 1'b1, 2'd1}, 35'd0, 35'd0}};
        vecs[3] = '{4'd5, 64'h1122334455000000, 2'd2,
                    {{32'h11223344, 1'b0, 2'd0}, {32'h55000000, 1'b1, 2'd1}, 35'd0}};
        vecs[4] = '{4'd4, 64'hDEADBEEF00000000, 2'd2,
                    {{32'hDEADBEEF, 1'b0, 2'd0}, {32'h00000000, 1'b1, 2'd0}, 35'd0}};
        vecs[5] = '{4'd6, 64'hA1A2A3A4A5A60000, 2'd2,
                    {{32'hA1A2A3A4, 1'b0, 2'd0}, {32'hA5A60000, 1'b1, 2'd2}, 35'd0}};

        repeat (2) @(negedge clk);
        check_reset_outputs("reset_state");
        reset = 1'b0;

        // Table-driven messages with no back-pressure
        for (int v = 0; v < 6; v++) begin
            msg_q.delete();
            for (int b = 0; b < int'(vecs[v].len); b++) begin
                logic [63:0] bb;
                bb = vecs[v].bytes;
                msg_q.push_back(bb[63-8*b -: 8]);
            end
            run_msg(100, 0, 200);
            exp_q.delete();
            for (int w = 0; w < int'(vecs[v].nw); w++) begin
                logic [104:0] ww;
                ww = vecs[v].words;
                exp_q.push_back(ww[104-35*w -: 35]);
            end
            compare_words($sformatf("vec%0d", v));
            finish_msg($sformatf("vec%0d", v), int'(vecs[v].len));
        end

        // Back-pressure: word held stable for 10 cycles, consumed exactly once
        buffer_full = 1'b1;
        push_byte(8'h5A, 1'b0);
        push_byte(8'h5B, 1'b0);
        push_byte(8'h5C, 1'b0);
        push_byte(8'h5D, 1'b0);
        check("bf_word_presented", {pad_in_ready, pad_in, pad_is_last}, {1'b1, 32'h5A5B5C5D, 1'b0});
        held_word = pad_in;
        stable = 1;
        repeat (10) begin
            @(negedge clk);
            if (!pad_in_ready || pad_in !== held_word || byte_ready || pad_is_last) stable = 0;
        end
        check("bf_hold_stable", 64'(stable), 64'd1);
        buffer_full = 1'b0;
        @(negedge clk);
        check("bf_single_consume", 64'({pad_in_ready, byte_ready}), 64'b01);

        // Asynchronous reset while a word is presented
        buffer_full = 1'b1;
        push_byte(8'h77, 1'b0);
        push_byte(8'h88, 1'b0);
        push_byte(8'h99, 1'b0);
        push_byte(8'hAA, 1'b0);
        check("pre_reset_hold", 64'(pad_in_ready), 64'd1);
        #2 reset = 1'b1;
        #1 check_reset_outputs("async_reset_in_hold");
        @(negedge clk);
        reset = 1'b0;
        buffer_full = 1'b0;

        // Asynchronous reset after a partial word, then a fresh message
        push_byte(8'h12, 1'b0);
        push_byte(8'h34, 1'b0);
        #2 reset = 1'b1;
        #1 check_reset_outputs("async_reset_partial");
        @(negedge clk);
        reset = 1'b0;
        msg_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        run_msg(100, 0, 200);
        exp_q = '{{32'h11223344, 1'b0, 2'd0}, {32'h55000000, 1'b1, 2'd1}};
        compare_words("after_reset");
        finish_msg("after_reset", 5);

        // msg_clear coinciding with a byte transfer drops that byte
        @(negedge clk);
        byte_valid = 1'b1; byte_data = 8'h01; byte_last = 1'b0;
        @(negedge clk);
        byte_data = 8'h02; msg_clear = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0; msg_clear = 1'b0;
        check("clear_back_to_fill", 64'({byte_ready, pad_in_ready}), 64'b10);
        msg_q = '{8'h03, 8'h04, 8'h05};
        run_msg(100, 0, 200);
        exp_q = '{{32'h03040500, 1'b1, 2'd3}};
        compare_words("clear_coincident");
        finish_msg("clear_coincident", 3);

        // Randomized messages with random valid gaps and back-pressure
        for (int m = 0; m < 40; m++) begin
            len = int'($urandom_range(1, 13));
            msg_q.delete();
            for (int b = 0; b < len; b++) msg_q.push_back(8'($urandom));
            build_exp();
            run_msg(70, 35, 2000);
            compare_words($sformatf("rand%0d", m));
            finish_msg($sformatf("rand%0d", m), len);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
